// File: rtl/dev_io_ctrl_pkg.sv
// Shared types and constants for the device I/O controller slice.
// Character width, default buffer depth and the two panel FSM encodings.
package dev_io_ctrl_pkg;

  localparam int unsigned CHAR_W         = 5;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef logic [CHAR_W-1:0] char_t;

  typedef enum logic {
    I_IDLE   = 1'b0,
    I_ACTIVE = 1'b1
  } in_state_t;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_HOLD = 1'b1
  } out_state_t;

endpackage

// File: rtl/dev_io_ctrl_if.sv
// Character handshakes between the controller, the I/O devices and the processing unit.
// The controller takes the slave view; the environment drives through master.
interface dev_io_ctrl_if;
  import dev_io_ctrl_pkg::*;

  logic  dev_input_val;
  char_t dev_input_data;
  logic  dev_input_rdy;

  logic  dev_output_rdy;
  char_t dev_output_data;
  logic  dev_output_ack;

  logic  pu_rd_val;
  char_t pu_rd_data;
  logic  pu_rd_req;

  logic  pu_wr_val;
  char_t pu_wr_data;
  logic  pu_wr_rdy;

  modport slave (
    input  dev_input_val, dev_input_data, dev_output_ack, pu_rd_req, pu_wr_val, pu_wr_data,
    output dev_input_rdy, dev_output_rdy, dev_output_data, pu_rd_val, pu_rd_data, pu_wr_rdy
  );

  modport master (
    output dev_input_val, dev_input_data, dev_output_ack, pu_rd_req, pu_wr_val, pu_wr_data,
    input  dev_input_rdy, dev_output_rdy, dev_output_data, pu_rd_val, pu_rd_data, pu_wr_rdy
  );

endinterface

// File: rtl/dev_io_ctrl_fifo.sv
// io_char_fifo: input character buffer, power-of-two depth, registered count.
// Head data reads zero while empty so the read port is quiet under reset.
module io_char_fifo
  import dev_io_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push,
  input  char_t         i_wdata,
  input  logic          i_pop,
  output char_t         o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  char_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dev_io_ctrl.sv
// dev_io_ctrl: panel-controlled input reader (device -> FIFO -> PU) and
// single-character output holder (PU -> device), each with its own FSM.
module dev_io_ctrl
  import dev_io_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start_input,
  input  logic         stop_input,
  input  logic         start_output,
  input  logic         stop_output,
  input  logic         continuous_input,
  output logic         input_active,
  output logic         output_active,
  dev_io_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  in_state_t     r_in_state,  w_in_next;
  out_state_t    r_out_state, w_out_next;
  logic          r_out_en;
  char_t         r_out_data;
  logic          w_push;
  logic          w_wr_fire;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  assign w_push    = bus.dev_input_val && bus.dev_input_rdy;
  assign w_wr_fire = bus.pu_wr_val && bus.pu_wr_rdy;

  io_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_wdata (bus.dev_input_data),
    .i_pop   (bus.pu_rd_req),
    .o_rdata (bus.pu_rd_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    if (resetn) assert (!(w_push && w_full));
  end

  // Input FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_in_state <= I_IDLE;
    else         r_in_state <= w_in_next;
  end

  always_comb begin
    w_in_next = r_in_state;
    case (r_in_state)
      I_IDLE:   if (start_input && !stop_input) w_in_next = I_ACTIVE;
      I_ACTIVE: if (stop_input || (w_push && !continuous_input)) w_in_next = I_IDLE;
      default:  w_in_next = I_IDLE;
    endcase
  end

  always_comb begin
    input_active      = (r_in_state == I_ACTIVE);
    bus.dev_input_rdy = input_active && (w_count != CW'(FIFO_DEPTH));
    bus.pu_rd_val     = !w_empty;
  end

  // Output FSM; the enable flag only gates new writes, a held character always completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_state <= O_IDLE;
      r_out_en    <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_state <= w_out_next;
      if (stop_output)       r_out_en <= 1'b0;
      else if (start_output) r_out_en <= 1'b1;
      if (w_wr_fire) r_out_data <= bus.pu_wr_data;
    end
  end

  always_comb begin
    w_out_next = r_out_state;
    case (r_out_state)
      O_IDLE:  if (w_wr_fire) w_out_next = O_HOLD;
      O_HOLD:  if (bus.dev_output_ack) w_out_next = O_IDLE;
      default: w_out_next = O_IDLE;
    endcase
  end

  always_comb begin
    bus.dev_output_rdy  = (r_out_state == O_HOLD);
    bus.dev_output_data = r_out_data;
    bus.pu_wr_rdy       = r_out_en && (r_out_state == O_IDLE);
    output_active       = r_out_en || (r_out_state == O_HOLD);
  end

endmodule

// File: tb/tb_dev_io_ctrl.sv
// Self-checking bench for dev_io_ctrl: directed scenarios plus a randomized run
// checked against a queue-based behavioural model.
module tb_dev_io_ctrl;

  localparam int unsigned FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic start_input = 1'b0, stop_input = 1'b0, start_output = 1'b0, stop_output = 1'b0;
  logic continuous_input = 1'b0;
  logic input_active, output_active;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  dev_io_ctrl_if bus ();

  dev_io_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .start_input      (start_input),
    .stop_input       (stop_input),
    .start_output     (start_output),
    .stop_output      (stop_output),
    .continuous_input (continuous_input),
    .input_active     (input_active),
    .output_active    (output_active),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_input = 0; stop_input = 0; start_output = 0; stop_output = 0;
    bus.dev_input_val = 0; bus.dev_input_data = '0; bus.dev_output_ack = 0;
    bus.pu_rd_req = 0; bus.pu_wr_val = 0; bus.pu_wr_data = '0;
  endtask

  function automatic logic [5:0] flags();
    return {bus.dev_input_rdy, bus.dev_output_rdy, bus.pu_rd_val, bus.pu_wr_rdy,
            input_active, output_active};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 resetn = 1'b0;
    #2;
    n_vec++;
    if (flags() !== 6'b0 || bus.dev_output_data !== 5'd0 || bus.pu_rd_data !== 5'd0) begin
      n_err++;
      $display("FAIL reset_state: flags=%b odata=%h rdata=%h, required all zero",
               flags(), bus.dev_output_data, bus.pu_rd_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    cycle();
  endtask

  task automatic test_continuous_read();
    continuous_input = 1;
    start_input = 1; cycle(); start_input = 0;
    n_vec++;
    if (input_active !== 1'b1 || bus.dev_input_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL cont_start: active=%b rdy=%b, required 1 1", input_active, bus.dev_input_rdy);
    end
    for (int unsigned k = 1; k <= 4; k++) begin
      bus.dev_input_val = 1; bus.dev_input_data = 5'(k);
      cycle();
      if (k == 1) begin
        n_vec++;
        if (bus.pu_rd_val !== 1'b1 || bus.pu_rd_data !== 5'h01) begin
          n_err++;
          $display("FAIL cont_first_visible: val=%b data=%h, required 1 01", bus.pu_rd_val, bus.pu_rd_data);
        end
      end
    end
    bus.dev_input_val = 0;
    n_vec++;
    if (bus.dev_input_rdy !== 1'b0 || input_active !== 1'b1) begin
      n_err++;
      $display("FAIL cont_full_rdy: rdy=%b active=%b, required 0 1", bus.dev_input_rdy, input_active);
    end
    for (int unsigned k = 1; k <= 4; k++) begin
      n_vec++;
      if (bus.pu_rd_val !== 1'b1 || bus.pu_rd_data !== 5'(k)) begin
        n_err++;
        $display("FAIL cont_pop_order: val=%b data=%h, required 1 %h", bus.pu_rd_val, bus.pu_rd_data, 5'(k));
      end
      bus.pu_rd_req = 1; cycle(); bus.pu_rd_req = 0;
    end
    n_vec++;
    if (bus.pu_rd_val !== 1'b0) begin
      n_err++;
      $display("FAIL cont_drained: val=%b, required 0", bus.pu_rd_val);
    end
    stop_input = 1; cycle(); stop_input = 0;
  endtask

  task automatic test_single_shot();
    continuous_input = 0;
    start_input = 1; cycle(); start_input = 0;
    bus.dev_input_val = 1; bus.dev_input_data = 5'h1F;
    cycle();
    n_vec++;
    if (input_active !== 1'b0 || bus.dev_input_rdy !== 1'b0 || bus.pu_rd_data !== 5'h1F) begin
      n_err++;
      $display("FAIL single_accept: active=%b rdy=%b data=%h, required 0 0 1f",
               input_active, bus.dev_input_rdy, bus.pu_rd_data);
    end
    repeat (3) cycle();
    bus.dev_input_val = 0;
    bus.pu_rd_req = 1; cycle(); bus.pu_rd_req = 0;
    n_vec++;
    if (bus.pu_rd_val !== 1'b0) begin
      n_err++;
      $display("FAIL single_one_only: val=%b, required 0", bus.pu_rd_val);
    end
  endtask

  task automatic test_full_pop();
    logic [4:0] v [4];
    continuous_input = 1;
    start_input = 1; cycle(); start_input = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      v[i] = 5'($urandom);
      bus.dev_input_val = 1; bus.dev_input_data = v[i];
      cycle();
    end
    n_vec++;
    if (bus.dev_input_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL full_rdy: rdy=%b, required 0", bus.dev_input_rdy);
    end
    bus.dev_input_data = ~v[0];
    bus.pu_rd_req = 1;
    cycle();
    bus.pu_rd_req = 0; bus.dev_input_val = 0;
    n_vec++;
    if (bus.dev_input_rdy !== 1'b1 || bus.pu_rd_data !== v[1]) begin
      n_err++;
      $display("FAIL full_pop_rdy: rdy=%b head=%h, required 1 %h", bus.dev_input_rdy, bus.pu_rd_data, v[1]);
    end
    for (int unsigned i = 1; i < 4; i++) begin
      n_vec++;
      if (bus.pu_rd_data !== v[i]) begin
        n_err++;
        $display("FAIL full_drain: data=%h, required %h", bus.pu_rd_data, v[i]);
      end
      bus.pu_rd_req = 1; cycle(); bus.pu_rd_req = 0;
    end
    bus.pu_rd_req = 1; cycle(); bus.pu_rd_req = 0;
    n_vec++;
    if (bus.pu_rd_val !== 1'b0 || bus.dev_input_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL empty_pop_ignored: val=%b rdy=%b, required 0 1", bus.pu_rd_val, bus.dev_input_rdy);
    end
    stop_input = 1; cycle(); stop_input = 0;
  endtask

  task automatic test_output_handshake();
    start_output = 1; cycle(); start_output = 0;
    n_vec++;
    if (bus.pu_wr_rdy !== 1'b1 || output_active !== 1'b1) begin
      n_err++;
      $display("FAIL out_enable: wr_rdy=%b active=%b, required 1 1", bus.pu_wr_rdy, output_active);
    end
    bus.pu_wr_val = 1; bus.pu_wr_data = 5'h0A; cycle(); bus.pu_wr_val = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      n_vec++;
      if (bus.dev_output_rdy !== 1'b1 || bus.dev_output_data !== 5'h0A || bus.pu_wr_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL out_hold: rdy=%b data=%h wr_rdy=%b, required 1 0a 0",
                 bus.dev_output_rdy, bus.dev_output_data, bus.pu_wr_rdy);
      end
      cycle();
    end
    bus.dev_output_ack = 1; cycle(); bus.dev_output_ack = 0;
    n_vec++;
    if (bus.dev_output_rdy !== 1'b0 || bus.pu_wr_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL out_ack: rdy=%b wr_rdy=%b, required 0 1", bus.dev_output_rdy, bus.pu_wr_rdy);
    end
    bus.dev_output_ack = 1; cycle(); bus.dev_output_ack = 0;
    n_vec++;
    if (bus.dev_output_rdy !== 1'b0 || bus.pu_wr_rdy !== 1'b1 || bus.dev_output_data !== 5'h0A) begin
      n_err++;
      $display("FAIL out_stray_ack: rdy=%b wr_rdy=%b data=%h, required 0 1 0a",
               bus.dev_output_rdy, bus.pu_wr_rdy, bus.dev_output_data);
    end
  endtask

  task automatic test_stop_races();
    bus.pu_wr_val = 1; bus.pu_wr_data = 5'h15; cycle(); bus.pu_wr_val = 0;
    stop_output = 1; cycle(); stop_output = 0;
    bus.pu_wr_val = 1; bus.pu_wr_data = 5'h07; cycle(); bus.pu_wr_val = 0;
    n_vec++;
    if (output_active !== 1'b1 || bus.dev_output_rdy !== 1'b1 || bus.dev_output_data !== 5'h15 ||
        bus.pu_wr_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL stop_during_hold: act=%b rdy=%b data=%h wr_rdy=%b, required 1 1 15 0",
               output_active, bus.dev_output_rdy, bus.dev_output_data, bus.pu_wr_rdy);
    end
    bus.dev_output_ack = 1; cycle(); bus.dev_output_ack = 0;
    n_vec++;
    if (output_active !== 1'b0 || bus.dev_output_rdy !== 1'b0 || bus.pu_wr_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL stop_complete: act=%b rdy=%b wr_rdy=%b, required 0 0 0",
               output_active, bus.dev_output_rdy, bus.pu_wr_rdy);
    end
    start_output = 1; stop_output = 1; start_input = 1; stop_input = 1;
    cycle();
    idle_inputs();
    n_vec++;
    if (output_active !== 1'b0 || input_active !== 1'b0) begin
      n_err++;
      $display("FAIL start_stop_same_cycle: out_act=%b in_act=%b, required 0 0", output_active, input_active);
    end
  endtask

  task automatic test_reset_mid();
    continuous_input = 1;
    start_input = 1; start_output = 1; cycle(); start_input = 0; start_output = 0;
    bus.dev_input_val = 1; bus.dev_input_data = 5'h11;
    bus.pu_wr_val = 1; bus.pu_wr_data = 5'h1B;
    cycle();
    bus.pu_wr_val = 0; bus.dev_input_data = 5'h12;
    cycle();
    bus.dev_input_val = 0;
    n_vec++;
    if (flags() !== 6'b111011 || bus.dev_output_data !== 5'h1B || bus.pu_rd_data !== 5'h11) begin
      n_err++;
      $display("FAIL midreset_setup: flags=%b odata=%h rdata=%h, required 111011 1b 11",
               flags(), bus.dev_output_data, bus.pu_rd_data);
    end
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if (flags() !== 6'b0 || bus.dev_output_data !== 5'd0 || bus.pu_rd_data !== 5'd0) begin
      n_err++;
      $display("FAIL midreset_async: flags=%b odata=%h rdata=%h, required all zero",
               flags(), bus.dev_output_data, bus.pu_rd_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    cycle();
    n_vec++;
    if (flags() !== 6'b0 || bus.pu_rd_data !== 5'd0) begin
      n_err++;
      $display("FAIL midreset_after: flags=%b rdata=%h, required all zero", flags(), bus.pu_rd_data);
    end
  endtask

  task automatic test_random();
    logic [4:0] q [$];
    logic in_act, out_en, hold, acc, pop, e_in_rdy, e_wr_rdy;
    logic [4:0] hdata, e_rd;
    logic [15:0] exp_v, act_v;
    apply_reset();
    in_act = 0; out_en = 0; hold = 0; hdata = '0;
    for (int unsigned c = 0; c < 3000; c++) begin
      start_input       = ($urandom_range(0, 7) == 0);
      stop_input        = ($urandom_range(0, 19) == 0);
      start_output      = ($urandom_range(0, 7) == 0);
      stop_output       = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) continuous_input = ($urandom_range(0, 3) != 0);
      bus.dev_input_val  = $urandom_range(0, 1);
      bus.dev_input_data = 5'($urandom);
      bus.pu_rd_req      = ($urandom_range(0, 2) == 0);
      bus.pu_wr_val      = $urandom_range(0, 1);
      bus.pu_wr_data     = 5'($urandom);
      bus.dev_output_ack = ($urandom_range(0, 2) == 0);

      e_in_rdy = in_act && (q.size() < FIFO_DEPTH);
      e_wr_rdy = out_en && !hold;
      e_rd     = (q.size() != 0) ? q[0] : 5'd0;
      exp_v = {e_in_rdy, hold, q.size() != 0, e_wr_rdy, in_act, out_en || hold, hdata, e_rd};
      act_v = {flags(), bus.dev_output_data, bus.pu_rd_data};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL random_cycle_%0d: got %h, required %h", c, act_v, exp_v);
      end

      acc = bus.dev_input_val && e_in_rdy;
      pop = bus.pu_rd_req && (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(bus.dev_input_data);
      if (in_act) in_act = !(stop_input || (acc && !continuous_input));
      else        in_act = start_input && !stop_input;
      if (hold) begin
        if (bus.dev_output_ack) hold = 0;
      end else if (bus.pu_wr_val && e_wr_rdy) begin
        hold = 1; hdata = bus.pu_wr_data;
      end
      if (stop_output)       out_en = 0;
      else if (start_output) out_en = 1;
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_continuous_read();
    test_single_shot();
    test_full_pop();
    test_output_handshake();
    test_stop_races();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
